// File: rtl/window_check_ctrl.sv
// rtl/window_check_ctrl.sv - session controller for the serial w-window checker
//
// Splits the serial w stream into back-to-back windows of WIN samples and pulses
// z when a window held exactly TARGET ones. A session runs NWIN windows, or with
// NWIN=0 it runs until abort.
//
// Optional feature macro: WINCHK_HITCNT_EN
//   defined   - hit_cnt counts z pulses of the current/last session, saturating
//   undefined - counter omitted, hit_cnt tied to 0
//
// Ports:
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   session request, sampled only in IDLE
//   w         in   serial data sample
//   abort     in   synchronous session cancel, sampled only in SAMPLE
//   busy      out  session in progress
//   z         out  one-cycle pulse, window hit
//   win_valid out  one-cycle pulse, window completed
//   done      out  one-cycle pulse, session completed normally
//   hit_cnt   out  [CW-1:0] hits in current/last session
module window_check_ctrl #(
  parameter int WIN    = 3,
  parameter int TARGET = 2,
  parameter int NWIN   = 4,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          w,
  input  logic          abort,
  output logic          busy,
  output logic          z,
  output logic          win_valid,
  output logic          done,
  output logic [CW-1:0] hit_cnt
);

  // idx never exceeds WIN-1 and ones never exceeds WIN, so one width serves both
  localparam int OW = $clog2(WIN + 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(WIN - 1);
  localparam logic [OW-1:0] TGT      = OW'(TARGET);
  localparam logic [15:0]   NWIN_L   = 16'(NWIN);

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t        state, state_d;
  logic [OW-1:0] idx, idx_d;
  logic [OW-1:0] ones, ones_d;
  logic [OW-1:0] ones_sum;
  logic [15:0]   wcnt, wcnt_d;
  logic [15:0]   wcnt_inc;
  logic          busy_d, z_d, wv_d, done_d;
  logic          hit;

  // ones_sum includes the sample captured on this edge, which matters on the
  // last sample of a window
  assign ones_sum = ones + OW'(w);
  assign wcnt_inc = wcnt + 16'd1;
  assign hit      = (ones_sum == TGT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      ones      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      z         <= 1'b0;
      win_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      ones      <= ones_d;
      wcnt      <= wcnt_d;
      busy      <= busy_d;
      z         <= z_d;
      win_valid <= wv_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    ones_d  = ones;
    wcnt_d  = wcnt;
    busy_d  = busy;
    z_d     = 1'b0;
    wv_d    = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          busy_d  = 1'b1;
          idx_d   = '0;
          ones_d  = '0;
          wcnt_d  = '0;
        end
      end
      SAMPLE: begin
        if (abort) begin
          // abort wins over the sample on this edge; partial window is dropped
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
          ones_d  = '0;
        end else if (idx == LAST_IDX) begin
          wv_d   = 1'b1;
          z_d    = hit;
          idx_d  = '0;
          ones_d = '0;
          wcnt_d = wcnt_inc;
          if ((NWIN != 0) && (wcnt_inc == NWIN_L)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = idx + OW'(1);
          ones_d = ones_sum;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef WINCHK_HITCNT_EN
  logic [CW-1:0] hit_q;
  logic          clr_hits;

  assign clr_hits = (state == IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= '0;
    end else if (clr_hits) begin
      hit_q <= '0;
    end else if (z_d && (hit_q != '1)) begin
      hit_q <= hit_q + CW'(1);
    end
  end

  assign hit_cnt = hit_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_window_check_ctrl.sv
// tb/tb_window_check_ctrl.sv - self-checking bench for window_check_ctrl
//
// dut: WIN=3 TARGET=2 NWIN=4 CW=8; dut_fr: WIN=3 TARGET=3 NWIN=0 CW=2
// (free-running session, small counter so saturation is reached).
module tb_window_check_ctrl;

  typedef struct {
    logic        z;
    logic        done;
    logic [31:0] hc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0, w = 1'b0, abort = 1'b0;
  logic       busy, z, win_valid, done;
  logic [7:0] hit_cnt;
  logic       start2 = 1'b0, w2 = 1'b0, abort2 = 1'b0;
  logic       busy2, z2, win_valid2, done2;
  logic [1:0] hit_cnt2;

  int   n_vec = 0;
  int   n_err = 0;
  int   hits = 0;
  int   fr_hits = 0;
  int   n_fr = 0;
  int   cyc = 0;
  int   last_z = -1;
  exp_t sb[$];
  exp_t sb2[$];
  exp_t e, e2;

  window_check_ctrl #(.WIN(3), .TARGET(2), .NWIN(4), .CW(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .w(w), .abort(abort),
    .busy(busy), .z(z), .win_valid(win_valid), .done(done), .hit_cnt(hit_cnt)
  );

  window_check_ctrl #(.WIN(3), .TARGET(3), .NWIN(0), .CW(2)) dut_fr (
    .clk(clk), .reset_n(reset_n), .start(start2), .w(w2), .abort(abort2),
    .busy(busy2), .z(z2), .win_valid(win_valid2), .done(done2), .hit_cnt(hit_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hc_exp(input int n, input int max);
`ifdef WINCHK_HITCNT_EN
    return (n > max) ? max : n;
`else
    return (n > max) ? 0 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    hits = 0;
  endtask

  // bits[2] is the first sample of the window
  task automatic send_window(input logic [2:0] bits, input bit last);
    logic hitb;
    hitb = ($countones(bits) == 2);
    if (hitb) hits++;
    sb.push_back('{hitb, last, hc_exp(hits, 255)});
    for (int i = 2; i >= 0; i--) begin
      w = bits[i];
      tick();
    end
    w = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_z"}, z, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (win_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_win_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("z", z, e.z);
          chk("done", done, e.done);
          chk("busy_at_win", busy, !e.done);
          chk("hit_cnt", hit_cnt, e.hc);
        end
      end else begin
        if (z) chk("z_without_win_valid", z, 0);
        if (done) chk("done_without_win_valid", done, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (win_valid2) begin
        n_fr++;
        if (sb2.size() == 0) begin
          chk("fr_unexpected_win_valid", 1, 0);
        end else begin
          e2 = sb2.pop_front();
          chk("fr_z", z2, e2.z);
          chk("fr_done", done2, e2.done);
          chk("fr_hit_cnt", hit_cnt2, e2.hc);
        end
        if (z2) begin
          if (last_z >= 0) chk("fr_z_period", cyc - last_z, 3);
          last_z = cyc;
        end
      end else begin
        if (z2) chk("fr_z_without_win_valid", z2, 0);
        if (done2) chk("fr_done_pulse", done2, 0);
      end
    end
  end

  initial begin
    // power-on reset, checked before any clock edge
    #1 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // single windows, then a full session ending with done
    start_session();
    send_window(3'b110, 0);
    send_window(3'b111, 0);
    send_window(3'b011, 0);
    send_window(3'b000, 1);

    // start held high: no re-trigger while busy, re-accepted right after done
    start = 1'b1;
    tick();
    hits = 0;
    send_window(3'b101, 0);
    send_window(3'b001, 0);
    send_window(3'b110, 0);
    send_window(3'b011, 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_hit_cnt_cleared", hit_cnt, 0);
    hits = 0;
    send_window(3'b111, 0);
    send_window(3'b110, 0);
    send_window(3'b000, 0);
    send_window(3'b101, 1);
    repeat (3) tick();

    // abort on the second sample of window 2
    start_session();
    send_window(3'b110, 0);
    w = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    w = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hit_cnt", hit_cnt, hc_exp(1, 255));
    repeat (5) tick();

    // abort ignored in IDLE; abort on the final sample of the last window
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    hits = 0;
    @(negedge clk);
    chk("idle_abort_ignored_busy", busy, 1);
    send_window(3'b110, 0);
    send_window(3'b101, 0);
    send_window(3'b011, 0);
    w = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    w = 1'b0;
    @(negedge clk);
    chk("final_abort_busy", busy, 0);
    chk("final_abort_hit_cnt", hit_cnt, hc_exp(3, 255));
    repeat (5) tick();

    // reset between edges mid-window, then start is needed to resume
    start_session();
    w = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("no_resume_without_start", busy, 0);
    start_session();
    send_window(3'b110, 0);
    send_window(3'b011, 0);
    send_window(3'b101, 0);
    send_window(3'b000, 1);
    @(negedge clk);
    chk("session_end_busy", busy, 0);
    repeat (3) tick();

    // free-running session: all ones, TARGET=3, stopped by abort
    w2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fr_hits++;
      sb2.push_back('{1'b1, 1'b0, hc_exp(fr_hits, 3)});
      repeat (3) tick();
    end
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    w2 = 1'b0;
    @(negedge clk);
    chk("fr_abort_busy", busy2, 0);
    chk("fr_hit_cnt_saturated", hit_cnt2, hc_exp(10, 3));
    repeat (4) tick();
    chk("fr_window_count", n_fr, 10);

    chk("sb_drained", sb.size(), 0);
    chk("fr_sb_drained", sb2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
